ln_stats_accum: RTL and testbench
=================================

Name: ln_stats_accum

Overview:
Upstream stage of the LayerNorm engine. It consumes the feature-map read stream, which arrives slice-major: for each channel slice of TOUT lanes, every pixel is delivered in turn. For each pixel (token) it accumulates the sum and sum-of-squares over all channels, holding the partials in a per-pixel RAM. After the last slice it emits one {sum, sumsq} record per pixel to the mean/variance stage.

Parameters:
TOUT, 32, lanes per input beat
DAT_DW, 8, signed lane width
LOG2_PIXEL, 8, log2 of pixel RAM depth (max 256 pixels)
SLICE_W, 6, width of slice count (max 63 slices, 2016 channels)
SUM_W, 20, signed sum width (>= DAT_DW+log2(TOUT)+SLICE_W)
SQ_W, 27, unsigned sum-of-squares width (>= 2*DAT_DW-2+log2(TOUT)+SLICE_W+1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; honoured only in IDLE
cfg_pixel_num  in  LOG2_PIXEL+1  pixels per slice (0..256)
cfg_slice_num  in  SLICE_W  channel slices
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when valid&ready
in_data  in  TOUT*DAT_DW  lane k in bits [k*DAT_DW +: DAT_DW], signed; padded lanes are zero
out_valid  out  1  record valid
out_ready  in  1  downstream accept
out_sum  out  SUM_W  signed channel sum for the pixel
out_sumsq  out  SQ_W  channel sum of squares for the pixel
out_pix  out  LOG2_PIXEL  pixel index
out_last  out  1  marks the record for the final pixel

Behaviour:
- Reset values: all outputs are 0; FSM is in IDLE; counters and FIFO are cleared. RAM contents are don't-care.
- FSM states:
  - IDLE: on start, latch cfg. If either cfg field is 0, go to DONE. Otherwise go to RUN.
  - RUN: accept beats.
  - DRAIN: entered after the beat with pix=pixel_num-1 and slice=slice_num-1 is accepted. Wait until the pipeline is empty and the FIFO is empty.
  - DONE: assert done for one cycle, then return to IDLE.
  - start is ignored outside IDLE.
- busy = (state != IDLE).
- Counters: pix_cnt counts 0..pixel_num-1 and wraps to 0, incrementing slice_cnt. Both advance only on an in_valid&in_ready handshake.
- Stage A (cycle of the handshake t):
  - Combinational adder tree over the lanes: lane_sum (sign-extended) and lane_sq (squares, unsigned). Both are registered at t.
  - RAM read address pix_cnt is issued at t; pix, first=(slice==0) and last=(slice==slice_num-1) are registered with the data.
- Stage B (t+1):
  - prev = 0 if first. Otherwise prev = forwarded B result if the B write address of cycle t equals this pixel, else RAM read data.
  - new = prev + lane values.
  - If not last, write new to the RAM at the end of t+1.
  - If last, push {new, pix, pix==pixel_num-1} into the output FIFO; no RAM write.
- Forwarding is mandatory. It is exercised only when pixel_num==1, since the RAM is read-old-on-collision.
- Output FIFO:
  - 2 entries; out_* are driven from the FIFO head; a pop happens on out_valid&out_ready.
  - Push and pop in the same cycle with the FIFO full: both occur.
- in_ready = (state==RUN) && (fifo_cnt + stageB_last_inflight < 2). No beat is ever dropped or duplicated under backpressure.
- Arithmetic: widths are sized so overflow cannot occur; no saturation. Square is (signed x)*(signed x) held as unsigned; -128 squared gives 16384.
- First-slice bypass means the RAM needs no clearing between layers.
- Reset mid-run: everything returns to reset values immediately and any in-flight beats are discarded. The next start behaves as a fresh run.
- Latency: handshake of a last-slice beat at t gives out_valid at t+2 when the FIFO was empty.

Decomposition:
- Package ln_stats_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - localparams LOG2_TOUT and PIX_DEPTH=1<<LOG2_PIXEL;
  - a lane-tree width helper function.
- Sub-module ln_stats_ram: simple dual-port, depth PIX_DEPTH, width SUM_W+SQ_W, 1-cycle synchronous read, read-old on same-address write.

Test Plan:
- Ones across all lanes: pixel_num=4, slice_num=1, all lanes=1 -> four records, each sum=32, sumsq=32. pix runs 0..3, out_last only on pix 3, then a done pulse.
- Negative extremes: pixel_num=3, slice_num=2, all lanes=-128 -> each pixel has sum=-8192 and sumsq=1048576.
- Forwarding: pixel_num=1, slice_num=4, back-to-back beats with lanes=slice+1 -> single record with sum=320, sumsq=960.
- Backpressure: pixel_num=8, slice_num=3, random lane data, out_ready low for 20 cycles mid-stream -> in_ready drops. All 8 records match the reference model, in order, with no loss or duplication.
- Reset mid-run: rst pulsed during slice 1 -> outputs are 0 and the FSM is in IDLE. A new run with pixel_num=2, slice_num=1, lanes=2 gives sum=64, sumsq=128, with no stale partials.
- Zero configuration: start with pixel_num=0 -> done one cycle after DONE entry, no out_valid. A start pulse while busy has no effect.

Source files
------------

// File: rtl/ln_stats_pkg.sv
// ---------------------------------------------------------------------------
// ln_stats_pkg
// Shared declarations for the LayerNorm statistics accumulator:
//   - state_e     : controller states
//   - LOG2_TOUT   : log2 of the default lane count
//   - PIX_DEPTH   : default depth of the per-pixel partial-sum RAM
//   - lane_tree_w : result width of an adder tree over N lanes of a given leaf width
// ---------------------------------------------------------------------------
package ln_stats_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_TOUT       = 32;
  localparam int DEF_LOG2_PIXEL = 8;
  localparam int LOG2_TOUT      = $clog2(DEF_TOUT);
  localparam int PIX_DEPTH      = 1 << DEF_LOG2_PIXEL;

  // Summing N values of leaf_w bits grows the result by ceil(log2(N)) bits.
  function automatic int lane_tree_w(input int leaf_w, input int lanes);
    return leaf_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/ln_stats_ram.sv
// ---------------------------------------------------------------------------
// ln_stats_ram
// Simple dual-port RAM holding per-pixel {sum, sumsq} partials.
// One-cycle synchronous read; a read to the address being written in the
// same cycle returns the old contents.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (sampled every cycle)
//   rdata_o : registered read data
// ---------------------------------------------------------------------------
module ln_stats_ram
  import ln_stats_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DW    = 47,
  parameter int DEPTH = PIX_DEPTH
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; every location
  // is written before it is read because the first slice bypasses the read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/ln_stats_accum.sv
// ---------------------------------------------------------------------------
// ln_stats_accum
// Accumulates per-pixel channel sum and sum-of-squares over a slice-major
// feature-map stream and emits one {sum, sumsq} record per pixel after the
// final slice.
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : one-cycle start pulse (honoured only in IDLE)
//   cfg_pixel_num         : pixels per slice (0..2**LOG2_PIXEL)
//   cfg_slice_num         : number of channel slices
//   busy / done           : run in progress / one-cycle completion pulse
//   in_valid/in_ready     : input beat handshake, in_data = TOUT signed lanes
//   out_valid/out_ready   : record handshake
//   out_sum / out_sumsq   : channel sum (signed) / sum of squares (unsigned)
//   out_pix / out_last    : pixel index / final-pixel marker
// Pipeline: stage A registers the lane tree and issues the RAM read; stage B
// adds the previous partial (zero, forwarded or RAM) and writes it back or
// pushes it into a 2-entry output FIFO on the final slice.
// ---------------------------------------------------------------------------
module ln_stats_accum
  import ln_stats_pkg::*;
#(
  parameter int TOUT       = DEF_TOUT,
  parameter int DAT_DW     = 8,
  parameter int LOG2_PIXEL = DEF_LOG2_PIXEL,
  parameter int SLICE_W    = 6,
  parameter int SUM_W      = 20,
  parameter int SQ_W       = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LOG2_PIXEL:0]      cfg_pixel_num,
  input  logic [SLICE_W-1:0]       cfg_slice_num,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TOUT*DAT_DW-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         out_sum,
  output logic [SQ_W-1:0]          out_sumsq,
  output logic [LOG2_PIXEL-1:0]    out_pix,
  output logic                     out_last
);

  localparam int PIX_W  = LOG2_PIXEL;
  localparam int CNT_W  = LOG2_PIXEL + 1;
  localparam int LSUM_W = lane_tree_w(DAT_DW, TOUT);
  localparam int LSQ_W  = lane_tree_w(2 * DAT_DW - 1, TOUT);
  localparam int RAM_W  = SUM_W + SQ_W;

  // ---------------- control state ----------------
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cfg_pix_q;
  logic [SLICE_W-1:0]   cfg_slice_q;
  logic [PIX_W-1:0]     pix_cnt_q;
  logic [SLICE_W-1:0]   slice_cnt_q;
  logic                 in_fire, pix_last, slice_last;

  // ---------------- stage A ----------------
  logic signed [LSUM_W-1:0] lsum;
  logic        [LSQ_W-1:0]  lsq;
  logic                     a_valid_q, a_first_q, a_last_q, a_plast_q;
  logic signed [LSUM_W-1:0] a_lsum_q;
  logic        [LSQ_W-1:0]  a_lsq_q;
  logic        [PIX_W-1:0]  a_pix_q;

  // ---------------- stage B ----------------
  logic        [RAM_W-1:0]  ram_rdata;
  logic signed [SUM_W-1:0]  ram_sum, prev_sum, new_sum, fwd_sum_q;
  logic        [SQ_W-1:0]   ram_sq, prev_sq, new_sq, fwd_sq_q;
  logic                     fwd_valid_q, fwd_hit, ram_we;
  logic        [PIX_W-1:0]  fwd_addr_q;

  // ---------------- output FIFO ----------------
  logic signed [SUM_W-1:0]  fifo_sum_q  [2];
  logic        [SQ_W-1:0]   fifo_sq_q   [2];
  logic        [PIX_W-1:0]  fifo_pix_q  [2];
  logic                     fifo_last_q [2];
  logic                     wr_ptr_q, rd_ptr_q;
  logic        [1:0]        fifo_cnt_q;
  logic                     fifo_push, fifo_pop, last_inflight;

  assign in_fire    = in_valid && in_ready;
  assign pix_last   = ({1'b0, pix_cnt_q} == (cfg_pix_q - CNT_W'(1)));
  assign slice_last = (slice_cnt_q == (cfg_slice_q - SLICE_W'(1)));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    // A last-slice beat in stage B will push next edge, so it reserves a slot.
    in_ready = (state_q == RUN) &&
               (({1'b0, fifo_cnt_q} + {2'b00, last_inflight}) < 3'd2);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ((cfg_pixel_num == '0) || (cfg_slice_num == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_fire && pix_last && slice_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (!a_valid_q && (fifo_cnt_q == 2'd0)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- config latch and position counters ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_pix_q   <= '0;
      cfg_slice_q <= '0;
      pix_cnt_q   <= '0;
      slice_cnt_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      cfg_pix_q   <= cfg_pixel_num;
      cfg_slice_q <= cfg_slice_num;
      pix_cnt_q   <= '0;
      slice_cnt_q <= '0;
    end else if (in_fire) begin
      if (pix_last) begin
        pix_cnt_q   <= '0;
        slice_cnt_q <= slice_cnt_q + SLICE_W'(1);
      end else begin
        pix_cnt_q   <= pix_cnt_q + PIX_W'(1);
      end
    end
  end

  // ---------------- stage A: lane adder tree ----------------
  always_comb begin
    logic signed [DAT_DW-1:0]   lane;
    logic signed [2*DAT_DW-1:0] lane_x;
    logic signed [2*DAT_DW-1:0] sq;
    lsum   = '0;
    lsq    = '0;
    lane   = '0;
    lane_x = '0;
    sq     = '0;
    for (int k = 0; k < TOUT; k++) begin
      lane   = in_data[k*DAT_DW +: DAT_DW];
      lane_x = (2*DAT_DW)'(lane);
      sq     = lane_x * lane_x;       // always >= 0, fits: (-128)^2 = 16384
      lsum   = lsum + LSUM_W'(lane);
      lsq    = lsq + LSQ_W'($unsigned(sq));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_first_q <= 1'b0;
      a_last_q  <= 1'b0;
      a_plast_q <= 1'b0;
      a_lsum_q  <= '0;
      a_lsq_q   <= '0;
      a_pix_q   <= '0;
    end else begin
      a_valid_q <= in_fire;
      if (in_fire) begin
        a_first_q <= (slice_cnt_q == '0);
        a_last_q  <= slice_last;
        a_plast_q <= pix_last;
        a_lsum_q  <= lsum;
        a_lsq_q   <= lsq;
        a_pix_q   <= pix_cnt_q;
      end
    end
  end

  // ---------------- partial-sum RAM ----------------
  ln_stats_ram #(
    .AW    (PIX_W),
    .DW    (RAM_W),
    .DEPTH (1 << LOG2_PIXEL)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (a_pix_q),
    .wdata_i ({new_sum, new_sq}),
    .raddr_i (pix_cnt_q),
    .rdata_o (ram_rdata)
  );

  assign ram_sum = ram_rdata[RAM_W-1 -: SUM_W];
  assign ram_sq  = ram_rdata[SQ_W-1:0];

  // ---------------- stage B: accumulate ----------------
  // The RAM returns old data when the read collides with the write landing
  // on the same edge (only possible with one pixel per slice), so that
  // write is replayed from fwd_*_q.
  always_comb begin
    fwd_hit       = fwd_valid_q && (fwd_addr_q == a_pix_q);
    prev_sum      = ram_sum;
    prev_sq       = ram_sq;
    if (a_first_q) begin
      prev_sum = '0;
      prev_sq  = '0;
    end else if (fwd_hit) begin
      prev_sum = fwd_sum_q;
      prev_sq  = fwd_sq_q;
    end
    new_sum       = prev_sum + SUM_W'(a_lsum_q);
    new_sq        = prev_sq + SQ_W'(a_lsq_q);
    ram_we        = a_valid_q && !a_last_q;
    fifo_push     = a_valid_q && a_last_q;
    last_inflight = a_valid_q && a_last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_sum_q   <= '0;
      fwd_sq_q    <= '0;
    end else begin
      fwd_valid_q <= ram_we;
      if (ram_we) begin
        fwd_addr_q <= a_pix_q;
        fwd_sum_q  <= new_sum;
        fwd_sq_q   <= new_sq;
      end
    end
  end

  // ---------------- output FIFO ----------------
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign fifo_pop  = out_valid && out_ready;
  assign out_sum   = fifo_sum_q[rd_ptr_q];
  assign out_sumsq = fifo_sq_q[rd_ptr_q];
  assign out_pix   = fifo_pix_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q];

  // Storage is cleared too so the out_* head reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_sum_q[i]  <= '0;
        fifo_sq_q[i]   <= '0;
        fifo_pix_q[i]  <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_sum_q[wr_ptr_q]  <= new_sum;
        fifo_sq_q[wr_ptr_q]   <= new_sq;
        fifo_pix_q[wr_ptr_q]  <= a_pix_q;
        fifo_last_q[wr_ptr_q] <= a_plast_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (fifo_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      // Push and pop together (even when full) leave the count unchanged.
      unique case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ln_stats_accum.sv
// ---------------------------------------------------------------------------
// tb_ln_stats_accum
// Directed bench for ln_stats_accum. Expected records are queued when a test
// is issued; a negedge monitor pops and compares each accepted record.
// ---------------------------------------------------------------------------
module tb_ln_stats_accum;

  localparam int TOUT   = 32;
  localparam int DAT_DW = 8;
  localparam int DW     = TOUT * DAT_DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [8:0]      cfg_pixel_num;
  logic [5:0]      cfg_slice_num;
  logic            busy, done;
  logic            in_valid, in_ready;
  logic [DW-1:0]   in_data;
  logic            out_valid, out_ready;
  logic [19:0]     out_sum;
  logic [26:0]     out_sumsq;
  logic [7:0]      out_pix;
  logic            out_last;

  ln_stats_accum dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_pixel_num (cfg_pixel_num),
    .cfg_slice_num (cfg_slice_num),
    .busy          (busy),
    .done          (done),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_sumsq     (out_sumsq),
    .out_pix       (out_pix),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [63:0] sum;
    logic signed [63:0] sq;
    logic signed [63:0] pix;
    logic signed [63:0] last;
  } rec_t;

  rec_t sb_q[$];
  rec_t mon_exp;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_rec(input longint s, input longint q, input int p, input bit l);
    rec_t r;
    r.sum  = s;
    r.sq   = q;
    r.pix  = p;
    r.last = l;
    sb_q.push_back(r);
  endtask

  // Monitor: compares every record accepted by the downstream.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_record: got pix=%0d sum=%0d, expected no record",
                 out_pix, $signed(out_sum));
      end else begin
        mon_exp = sb_q.pop_front();
        check("rec_sum",   64'($signed(out_sum)), mon_exp.sum);
        check("rec_sumsq", 64'(out_sumsq),        mon_exp.sq);
        check("rec_pix",   64'(out_pix),          mon_exp.pix);
        check("rec_last",  64'(out_last),         mon_exp.last);
      end
    end
  end

  function automatic logic [DW-1:0] fill(input logic signed [7:0] v);
    return {TOUT{v}};
  endfunction

  // Reference: channel sum and sum of squares of one beat.
  task automatic model_acc(input logic [DW-1:0] d, inout longint s, inout longint q);
    logic signed [7:0] b;
    longint x;
    for (int k = 0; k < TOUT; k++) begin
      b = d[k*DAT_DW +: DAT_DW];
      x = longint'(b);
      s += x;
      q += x * x;
    end
  endtask

  task automatic do_start(input int pn, input int sn);
    cfg_pixel_num = 9'(pn);
    cfg_slice_num = 6'(sn);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n >= 200) break;
    end
    if (in_ready) begin
      @(posedge clk);
      #1;
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 64'(done), 1);
    @(negedge clk);
    check({name, "_done_pulse_end"}, 64'(done), 0);
    check({name, "_idle"}, 64'(busy), 0);
    check({name, "_sb_empty"}, 64'(sb_q.size()), 0);
  endtask

  logic [DW-1:0] bp_data [3][8];
  longint        bp_s [8];
  longint        bp_q [8];
  bit            saw_low;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_pixel_num = '0;
    cfg_slice_num = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_busy",      64'(busy),      0);
    check("rst_done",      64'(done),      0);
    check("rst_in_ready",  64'(in_ready),  0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_sum",   64'(out_sum),   0);
    check("rst_out_sumsq", 64'(out_sumsq), 0);
    check("rst_out_pix",   64'(out_pix),   0);
    check("rst_out_last",  64'(out_last),  0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ---- ones across all lanes; a start while busy must be ignored ----
    for (int p = 0; p < 4; p++) expect_rec(32, 32, p, p == 3);
    do_start(4, 1);
    check("ones_busy", 64'(busy), 1);
    do_start(2, 2);
    for (int p = 0; p < 4; p++) send(fill(8'sd1));
    wait_done("ones");

    // ---- negative extremes ----
    for (int p = 0; p < 3; p++) expect_rec(-8192, 1048576, p, p == 2);
    do_start(3, 2);
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 3; p++) send(fill(-8'sd128));
    wait_done("neg");

    // ---- forwarding (one pixel, back-to-back) and first-record latency ----
    expect_rec(320, 960, 0, 1'b1);
    do_start(1, 4);
    for (int s = 0; s < 4; s++) send(fill(8'(s + 1)));
    @(negedge clk);
    check("fwd_latency_t1", 64'(out_valid), 0);
    @(negedge clk);
    check("fwd_latency_t2", 64'(out_valid), 1);
    wait_done("fwd");

    // ---- backpressure with random data ----
    for (int p = 0; p < 8; p++) begin
      bp_s[p] = 0;
      bp_q[p] = 0;
    end
    for (int s = 0; s < 3; s++)
      for (int p = 0; p < 8; p++) begin
        for (int w = 0; w < DW / 32; w++) bp_data[s][p][w*32 +: 32] = $urandom;
        model_acc(bp_data[s][p], bp_s[p], bp_q[p]);
      end
    for (int p = 0; p < 8; p++) expect_rec(bp_s[p], bp_q[p], p, p == 7);
    saw_low = 1'b0;
    do_start(8, 3);
    fork
      begin
        for (int s = 0; s < 3; s++)
          for (int p = 0; p < 8; p++) send(bp_data[s][p]);
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if (busy && !in_ready) saw_low = 1'b1;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("bp_in_ready_dropped", 64'(saw_low), 1);
    wait_done("bp");

    // ---- reset mid-run, then a fresh run ----
    do_start(4, 3);
    for (int p = 0; p < 4; p++) send(fill(8'sd5));
    for (int p = 0; p < 2; p++) send(fill(8'sd5));
    rst = 1'b1;
    #3;
    check("mid_rst_busy",      64'(busy),      0);
    check("mid_rst_in_ready",  64'(in_ready),  0);
    check("mid_rst_out_valid", 64'(out_valid), 0);
    check("mid_rst_out_sum",   64'(out_sum),   0);
    @(posedge clk);
    #1 rst = 1'b0;
    expect_rec(64, 128, 0, 1'b0);
    expect_rec(64, 128, 1, 1'b1);
    do_start(2, 1);
    for (int p = 0; p < 2; p++) send(fill(8'sd2));
    wait_done("post_rst");

    // ---- zero configuration ----
    do_start(0, 3);
    @(negedge clk);
    check("zero_pix_done",      64'(done),      1);
    check("zero_pix_out_valid", 64'(out_valid), 0);
    @(negedge clk);
    check("zero_pix_done_end",  64'(done),      0);
    check("zero_pix_idle",      64'(busy),      0);
    do_start(3, 0);
    @(negedge clk);
    check("zero_slice_done",    64'(done),      1);
    @(negedge clk);
    check("zero_slice_idle",    64'(busy),      0);
    check("final_sb_empty",     64'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
